spi_sector_reader: RTL and testbench

- Sequencer FSM directly upstream of the SPI sector counter: drives its initS/ldS/decS/cntIn controls and consumes its finished flag.
- On start, issues a single SPI-flash READ (0x03 + 24-bit address), streams sectorCount sectors of SECTOR_BYTES bytes into local memory, then signals done.
- The sector counter is the only authority on remaining sectors; this block keeps only a byte-in-sector counter.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_shift_engine.sv | 86 ++++++++
 rtl/spi_sector_reader.sv | 207 ++++++++++++++++++++
 tb/tb_spi_sector_reader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and a width helper for the SPI sector reader.
package spi_pkg;

  // SPI flash READ opcode and the length of opcode + 24-bit address.
  localparam logic [7:0]  READ_CMD = 8'h03;
  localparam int unsigned CMD_BITS = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StCmd,
    StData,
    StWrite,
    StSecChk,
    StFinish
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SCLK divider plus TX/RX shift registers. The FSM decides when the clock runs;
// this block only produces the edges and moves bits on them.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,     // abandon everything, SCLK low
  input  logic        load_i,      // start of a command phase
  input  logic        run_i,       // SCLK toggles while high, holds otherwise
  input  logic        shift_tx_i,  // advance MOSI on falling edges
  input  logic [31:0] tx_word_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic [7:0]  rx_byte_o
);

  localparam int unsigned DivW = cnt_width(CLK_DIV);

  logic [DivW-1:0] div_q, div_d;
  logic            sclk_q, sclk_d;
  logic [31:0]     tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic            tick;

  // A tick marks the last system cycle of an SCLK half-period.
  assign tick   = run_i && (div_q == DivW'(CLK_DIV - 1));
  assign rise_o = tick && !sclk_q;
  assign fall_o = tick && sclk_q;

  // Divider, SCLK level and shifters next-state.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (clear_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
      tx_d   = '0;
      rx_d   = '0;
    end else if (load_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
      tx_d   = tx_word_i;
      rx_d   = '0;
    end else if (run_i) begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        sclk_d = !sclk_q;
      end
      // Mode 0: sample on the rising edge, launch on the falling edge.
      if (rise_o) begin
        rx_d = {rx_q[6:0], miso_i};
      end
      if (fall_o && shift_tx_i) begin
        tx_d = {tx_q[30:0], 1'b0};
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[31];
  assign rx_byte_o = rx_q;

endmodule

// File: rtl/spi_sector_reader.sv
// Sequencer that reads sectorCount sectors from SPI flash into local memory,
// driving an external sector counter that owns the remaining-sector count.
module spi_sector_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned MEM_ADDR_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [7:0]            sectorCount_i,
  input  logic [23:0]           startAddr_i,
  input  logic                  finished_i,
  output logic                  initS_o,
  output logic                  ldS_o,
  output logic                  decS_o,
  output logic [7:0]            cntIn_o,
  output logic                  spiSclk_o,
  output logic                  spiCs_n_o,
  output logic                  spiMosi_o,
  input  logic                  spiMiso_i,
  output logic                  memWrite_o,
  output logic [MEM_ADDR_W-1:0] memAddr_o,
  output logic [7:0]            memData_o,
  output logic                  busy_o,
  output logic                  done_o
);

  import spi_pkg::*;

  localparam int unsigned     ByteW    = cnt_width(SECTOR_BYTES);
  localparam logic [ByteW-1:0] LastByte = ByteW'(SECTOR_BYTES - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_in_q, cnt_in_d;
  logic [23:0]             addr_q, addr_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ByteW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic                    init_q, init_d;
  logic                    cs_n_q, cs_n_d;

  logic                    abort_act;
  logic                    last_byte;
  logic                    eng_load;
  logic                    eng_run;
  logic                    eng_shift_tx;
  logic                    eng_rise;
  logic                    eng_fall;
  logic [7:0]              rx_byte;

  assign abort_act    = abort_i && (state_q != StIdle);
  assign last_byte    = (byte_cnt_q == LastByte);
  assign eng_run      = ((state_q == StCmd) || (state_q == StData)) && !abort_act;
  assign eng_shift_tx = (state_q == StCmd);

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (abort_act),
    .load_i     (eng_load),
    .run_i      (eng_run),
    .shift_tx_i (eng_shift_tx),
    .tx_word_i  ({READ_CMD, addr_q}),
    .miso_i     (spiMiso_i),
    .sclk_o     (spiSclk_o),
    .mosi_o     (spiMosi_o),
    .rise_o     (eng_rise),
    .fall_o     (eng_fall),
    .rx_byte_o  (rx_byte)
  );

  // FSM next-state, counter updates and decoded strobes.
  always_comb begin
    state_d    = state_q;
    cnt_in_d   = cnt_in_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    init_d     = 1'b0;
    eng_load   = 1'b0;
    ldS_o      = 1'b0;
    decS_o     = 1'b0;
    memWrite_o = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_in_d   = sectorCount_i;
          addr_d     = startAddr_i;
          mem_addr_d = '0;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        ldS_o   = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        // A zero-sector request finishes without ever touching the bus.
        if (finished_i) begin
          state_d = StFinish;
        end else begin
          eng_load  = 1'b1;
          bit_cnt_d = '0;
          state_d   = StCmd;
        end
      end
      StCmd: begin
        if (eng_fall) begin
          // Wraps to zero on the last command bit, ready for the data phase.
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (eng_fall) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        memWrite_o = 1'b1;
        mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);
        bit_cnt_d  = '0;
        if (last_byte) begin
          decS_o     = 1'b1;
          byte_cnt_d = '0;
          state_d    = StSecChk;
        end else begin
          byte_cnt_d = byte_cnt_q + ByteW'(1);
          state_d    = StData;
        end
      end
      StSecChk: begin
        // The flash keeps streaming, so no new command between sectors.
        state_d = finished_i ? StFinish : StData;
      end
      StFinish: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything, including a pending byte write.
    if (abort_act) begin
      state_d    = StIdle;
      init_d     = 1'b1;
      eng_load   = 1'b0;
      mem_addr_d = mem_addr_q;
      byte_cnt_d = byte_cnt_q;
      ldS_o      = 1'b0;
      decS_o     = 1'b0;
      memWrite_o = 1'b0;
      done_o     = 1'b0;
    end

    // Registered chip select follows the state being entered.
    cs_n_d = !((state_d == StCmd) || (state_d == StData) ||
               (state_d == StWrite) || (state_d == StSecChk));
  end

  // FSM state, latches and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_in_q   <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      init_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_in_q   <= cnt_in_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      init_q     <= init_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign initS_o   = init_q;
  assign cntIn_o   = cnt_in_q;
  assign spiCs_n_o = cs_n_q;
  assign memAddr_o = mem_addr_q;
  assign memData_o = rx_byte;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_sector_reader.sv
// Scoreboard bench: stimulus pushes expected memory writes, a monitor pops and
// compares them whenever the reader strobes memWrite.
module tb_spi_sector_reader;

  localparam int unsigned ClkDiv  = 2;
  localparam int unsigned SecB    = 4;

  logic        clk, rst, start, abort, finished, spiMiso;
  logic [7:0]  sectorCount;
  logic [23:0] startAddr;
  logic        initS, ldS, decS, spiSclk, spiCs_n, spiMosi, memWrite, busy, done;
  logic [7:0]  cntIn, memData;
  logic [15:0] memAddr;

  // Narrow-address twin, fed identically, used to observe address wrap.
  logic        w_initS, w_ldS, w_decS, w_spiSclk, w_spiCs_n, w_spiMosi, w_memWrite;
  logic        w_busy, w_done;
  logic [7:0]  w_cntIn, w_memData;
  logic [1:0]  w_memAddr;

  spi_sector_reader #(
    .CLK_DIV      (ClkDiv),
    .SECTOR_BYTES (SecB),
    .MEM_ADDR_W   (16)
  ) dut (
    .clk_i (clk), .rst_i (rst), .start_i (start), .abort_i (abort),
    .sectorCount_i (sectorCount), .startAddr_i (startAddr), .finished_i (finished),
    .initS_o (initS), .ldS_o (ldS), .decS_o (decS), .cntIn_o (cntIn),
    .spiSclk_o (spiSclk), .spiCs_n_o (spiCs_n), .spiMosi_o (spiMosi), .spiMiso_i (spiMiso),
    .memWrite_o (memWrite), .memAddr_o (memAddr), .memData_o (memData),
    .busy_o (busy), .done_o (done)
  );

  spi_sector_reader #(
    .CLK_DIV      (ClkDiv),
    .SECTOR_BYTES (SecB),
    .MEM_ADDR_W   (2)
  ) dut_wrap (
    .clk_i (clk), .rst_i (rst), .start_i (start), .abort_i (abort),
    .sectorCount_i (sectorCount), .startAddr_i (startAddr), .finished_i (finished),
    .initS_o (w_initS), .ldS_o (w_ldS), .decS_o (w_decS), .cntIn_o (w_cntIn),
    .spiSclk_o (w_spiSclk), .spiCs_n_o (w_spiCs_n), .spiMosi_o (w_spiMosi), .spiMiso_i (spiMiso),
    .memWrite_o (w_memWrite), .memAddr_o (w_memAddr), .memData_o (w_memData),
    .busy_o (w_busy), .done_o (w_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sector counter model; the twin behaves identically so it shares this one.
  logic [7:0] sc;
  always @(posedge clk) begin
    if (rst)        sc <= 8'd0;
    else if (initS) sc <= 8'd0;
    else if (ldS)   sc <= cntIn;
    else if (decS)  sc <= sc - 8'd1;
  end
  assign finished = (sc == 8'd0);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Flash model: collects 32 command bits, then returns 0xA0, 0xA1, ...
  logic [31:0] cmd_sr;
  int          nbits, byte_idx, bitpos;
  initial begin : flash_model
    logic       prev_cs;
    logic [7:0] bv;
    prev_cs  = 1'b1;
    spiMiso  = 1'b0;
    cmd_sr   = '0;
    nbits    = 0;
    byte_idx = 0;
    bitpos   = 0;
    forever begin
      @(spiSclk or spiCs_n);
      if (prev_cs && !spiCs_n) begin
        cmd_sr = '0; nbits = 0; byte_idx = 0; bitpos = 0; spiMiso = 1'b0;
      end else if (!spiCs_n && spiSclk) begin
        if (nbits < 32) begin
          cmd_sr = {cmd_sr[30:0], spiMosi};
          nbits++;
        end
      end else if (!spiCs_n && !spiSclk && nbits == 32) begin
        bv      = 8'hA0 + 8'(byte_idx);
        spiMiso = bv[7-bitpos];
        bitpos++;
        if (bitpos == 8) begin
          bitpos = 0;
          byte_idx++;
        end
      end
      prev_cs = spiCs_n;
    end
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        dec;
    logic [15:0] gap;
  } wr_t;

  wr_t exp_q[$];
  int  exp_done   = 0;
  int  writes_seen = 0;

  // Monitor: pops one expectation per memWrite, checks strobes and timing.
  initial begin : monitor
    logic prev_cs;
    int   ref_cyc;
    wr_t  e;
    prev_cs = 1'b1;
    ref_cyc = 0;
    forever begin
      @(negedge clk);
      if (prev_cs && !spiCs_n) ref_cyc = cyc;
      prev_cs = spiCs_n;
      check("strobe_excl", 64'($countones({initS, ldS, decS}) > 1), 64'd0);
      if (memWrite) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   memAddr, memData);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", memAddr, e.addr);
          check("wr_data", memData, e.data);
          check("wr_decS", decS, e.dec);
          check("wr_gap", cyc - ref_cyc, e.gap);
          check("wrap_we", w_memWrite, 1'b1);
          check("wrap_addr", w_memAddr, e.addr[1:0]);
        end
        ref_cyc = cyc;
        writes_seen++;
      end else if (decS) begin
        check("stray_decS", decS, 1'b0);
      end
      if (done) begin
        check("done_expected", exp_done > 0, 1'b1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic push_bytes(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = 16'(i);
      e.data = 8'hA0 + 8'(i);
      e.dec  = ((i % SecB) == SecB - 1);
      e.gap  = (i == 0) ? 16'd160 : (((i % SecB) == 0) ? 16'd34 : 16'd33);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input logic [7:0] cnt, input logic [23:0] addr);
    @(negedge clk);
    sectorCount = cnt;
    startAddr   = addr;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_writes(input int target, input string name);
    int k = 0;
    while (writes_seen < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, writes_seen >= target, 1'b1);
  endtask

  initial begin : stimulus
    int base;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sectorCount = '0; startAddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cs_n", spiCs_n, 1'b1);
    check("rst_sclk", spiSclk, 1'b0);
    check("rst_mosi", spiMosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cntIn", cntIn, 8'd0);
    check("rst_memAddr", memAddr, 16'd0);
    check("rst_strobes", {initS, ldS, decS, memWrite, done}, 5'd0);

    // Two sectors from 0x012345, with a start pulse ignored mid-transfer
    base = writes_seen;
    push_bytes(8);
    exp_done = 1;
    start_xfer(8'd2, 24'h012345);
    wait_writes(base + 3, "wait_3_writes");
    repeat (2) @(negedge clk);
    sectorCount = 8'd9;
    startAddr   = 24'h000000;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_start_cntIn", cntIn, 8'd2);
    check("busy_start_memAddr", memAddr, 16'd3);
    check("busy_start_busy", busy, 1'b1);
    wait_idle("main_idle");
    check("main_cmd", cmd_sr, 32'h03012345);
    check("main_cs_after", spiCs_n, 1'b1);
    check("main_left", exp_q.size(), 0);
    check("main_done_left", exp_done, 0);

    // Zero sectors: ldS at t+1, done at t+3, bus untouched
    exp_done = 1;
    @(negedge clk);
    sectorCount = 8'd0;
    startAddr   = 24'h000040;
    start       = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("zero_ldS", ldS, k == 1);
      check("zero_done", done, k == 3);
      check("zero_cs", spiCs_n, 1'b1);
      check("zero_sclk", spiSclk, 1'b0);
    end
    check("zero_busy", busy, 1'b0);
    check("zero_done_left", exp_done, 0);

    // Abort mid byte 5 (second sector of three)
    base = writes_seen;
    push_bytes(5);
    start_xfer(8'd3, 24'h000100);
    wait_writes(base + 5, "wait_5_writes");
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs", spiCs_n, 1'b1);
    check("abort_initS", initS, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_sclk", spiSclk, 1'b0);
    @(negedge clk);
    check("abort_initS_once", initS, 1'b0);
    repeat (150) @(negedge clk);
    check("abort_memAddr", memAddr, 16'd5);
    check("abort_left", exp_q.size(), 0);

    // Synchronous reset during the command phase
    start_xfer(8'd2, 24'h111111);
    begin
      int k = 0;
      while (spiCs_n && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("rst_test_cmd_entry", spiCs_n, 1'b0);
    end
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cs", spiCs_n, 1'b1);
    check("midrst_sclk", spiSclk, 1'b0);
    check("midrst_mosi", spiMosi, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cntIn", cntIn, 8'd0);
    check("midrst_memAddr", memAddr, 16'd0);
    check("midrst_memData", memData, 8'd0);
    check("midrst_strobes", {initS, ldS, decS, memWrite, done}, 5'd0);
    repeat (5) @(negedge clk);

    // Fresh single-sector transfer after reset
    push_bytes(4);
    exp_done = 1;
    start_xfer(8'd1, 24'hABCDEF);
    wait_idle("fresh_idle");
    check("fresh_cmd", cmd_sr, 32'h03ABCDEF);
    check("fresh_left", exp_q.size(), 0);
    check("fresh_done_left", exp_done, 0);
    check("fresh_memAddr", memAddr, 16'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
